// File: rtl/map_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : map_pkg
//  Purpose  : Shared definitions for the tile map renderer: controller state
//             encoding, default geometry of the playfield window, sprite-sheet
//             texture constants and the texture address helper.
//  Revision : 1.0  initial release
// ============================================================================
package map_pkg;

  // Default playfield geometry (tiles and half-resolution pixels)
  localparam int c_MAP_W_DEF    = 40;
  localparam int c_MAP_H_DEF    = 40;
  localparam int c_TILE_DEF     = 5;
  localparam int c_ORG_X_DEF    = 60;
  localparam int c_ORG_Y_DEF    = 30;

  // Sprite-sheet layout of the wall texture
  localparam int c_TEX_ROW_DEF  = 120;
  localparam int c_FB_W_DEF     = 320;
  localparam int c_FB_DEPTH_DEF = 76800;

  // Default player collision box in tiles
  localparam int c_Q_W_DEF      = 4;
  localparam int c_Q_H_DEF      = 4;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2,
    S_SCAN  = 2'd3
  } map_state_t;

  // Linear sprite-sheet address of texel (ox, oy) of the wall texture,
  // wrapped to the sheet depth.
  function automatic logic [16:0] tex_addr(
    input logic [7:0] ox,
    input logic [7:0] oy,
    input int         tex_row,
    input int         fb_w,
    input int         fb_depth
  );
    logic [31:0] lin;
    lin = {24'd0, ox} + ({24'd0, oy} + $unsigned(tex_row)) * $unsigned(fb_w);
    return 17'(lin % $unsigned(fb_depth));
  endfunction

endpackage
`default_nettype wire

// File: rtl/map_row_window.sv
`default_nettype none
// ============================================================================
//  Module   : map_row_window
//  Purpose  : Collision test of one map row against a Q_W-tile wide window
//             starting at column i_col. Any window column outside the map
//             counts as wall.
//  Ports    : i_row  - one map row, bit MAP_W-1-c holds column c
//             i_col  - window left column (tiles)
//             o_hit  - OR of the window bits (out-of-range columns read as 1)
//  Revision : 1.0  initial release
// ============================================================================
module map_row_window #(
  parameter int MAP_W = 40,
  parameter int Q_W   = 4
) (
  input  logic [MAP_W-1:0] i_row,
  input  logic [7:0]       i_col,
  output logic             o_hit
);

  localparam logic [7:0] c_MAP_W8 = 8'(MAP_W);

  logic [Q_W-1:0] w_bit;

  for (genvar k = 0; k < Q_W; k++) begin : g_col
    logic [7:0]       w_col;
    logic [MAP_W-1:0] w_sh;
    assign w_col = i_col + 8'(k);
    // Shifting left by the column brings column c into the MSB position,
    // avoiding a variable descending bit index.
    assign w_sh     = i_row << w_col;
    assign w_bit[k] = (w_col >= c_MAP_W8) | w_sh[MAP_W-1];
  end

  assign o_hit = |w_bit;

endmodule
`default_nettype wire

// File: rtl/tile_map_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tile_map_renderer
//  Purpose  : Loadable MAP_W x MAP_H wall-tile map. Streams the map in row by
//             row, renders it into the VGA pixel stream through a 2-stage
//             pipeline and answers player-box collision queries by scanning
//             Q_H rows, one per cycle.
//  Ports    : clk, rst                    - clock, synchronous active-high reset
//             load_start                  - restart map loading at row 0
//             row_valid/row_ready/row_data- map row stream (bit MAP_W-1-c = col c)
//             map_ready                   - whole map loaded
//             h_cnt, v_cnt                - VGA counters
//             pixel_addr, is_object       - sprite address / wall flag, 2 cycles later
//             q_valid/q_ready/q_x/q_y     - collision query (box top-left in tiles)
//             r_valid, r_hit              - one-cycle collision result
//  Revision : 1.0  initial release
// ============================================================================
module tile_map_renderer
  import map_pkg::*;
#(
  parameter int MAP_W    = c_MAP_W_DEF,
  parameter int MAP_H    = c_MAP_H_DEF,
  parameter int TILE     = c_TILE_DEF,
  parameter int ORG_X    = c_ORG_X_DEF,
  parameter int ORG_Y    = c_ORG_Y_DEF,
  parameter int TEX_ROW  = c_TEX_ROW_DEF,
  parameter int FB_W     = c_FB_W_DEF,
  parameter int FB_DEPTH = c_FB_DEPTH_DEF,
  parameter int Q_W      = c_Q_W_DEF,
  parameter int Q_H      = c_Q_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic [MAP_W-1:0] row_data,
  output logic             map_ready,
  input  logic [9:0]       h_cnt,
  input  logic [9:0]       v_cnt,
  output logic [16:0]      pixel_addr,
  output logic             is_object,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [6:0]       q_x,
  input  logic [6:0]       q_y,
  output logic             r_valid,
  output logic             r_hit
);

  localparam int         c_ROW_AW   = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam logic [7:0] c_MAP_H8   = 8'(MAP_H);
  localparam logic [7:0] c_Q_H8     = 8'(Q_H);
  localparam logic [9:0] c_ORG_X10  = 10'(ORG_X);
  localparam logic [9:0] c_ORG_Y10  = 10'(ORG_Y);
  localparam logic [9:0] c_X_END10  = 10'(ORG_X + MAP_W * TILE);
  localparam logic [9:0] c_Y_END10  = 10'(ORG_Y + MAP_H * TILE);
  localparam logic [9:0] c_TILE10   = 10'(TILE);

  // --------------------------------------------------------------------------
  // Map storage and controller registers
  // --------------------------------------------------------------------------
  logic [MAP_W-1:0] r_map [MAP_H];

  map_state_t r_state;
  logic [7:0] r_row;       // load row index, later the scan row
  logic [7:0] r_cnt;       // rows scanned so far in the current query
  logic [7:0] r_qx;        // captured box left column
  logic       r_acc;       // hit accumulator
  logic       r_row_ready;
  logic       r_map_ready;
  logic       r_q_ready;
  logic       r_res_valid;
  logic       r_res_hit;

  logic w_row_wr;
  logic [MAP_W-1:0] w_scan_row;
  logic w_win_hit;
  logic w_acc_next;

  // load_start takes priority, so a coincident row beat is discarded.
  assign w_row_wr = (r_state == S_LOAD) & row_valid & r_row_ready & ~load_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAP_H; i++) begin
        r_map[i] <= '0;
      end
    end else if (w_row_wr) begin
      r_map[r_row[c_ROW_AW-1:0]] <= row_data;
    end
  end

  // --------------------------------------------------------------------------
  // Collision scan: rows beyond the map read as solid wall.
  // --------------------------------------------------------------------------
  assign w_scan_row = (r_row < c_MAP_H8) ? r_map[r_row[c_ROW_AW-1:0]] : '1;

  map_row_window #(
    .MAP_W (MAP_W),
    .Q_W   (Q_W)
  ) u_row_window (
    .i_row (w_scan_row),
    .i_col (r_qx),
    .o_hit (w_win_hit)
  );

  assign w_acc_next = r_acc | w_win_hit;

  // --------------------------------------------------------------------------
  // Controller FSM with registered handshake and status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_cnt       <= '0;
      r_qx        <= '0;
      r_acc       <= 1'b0;
      r_row_ready <= 1'b0;
      r_map_ready <= 1'b0;
      r_q_ready   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_hit   <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (load_start) begin
        // Restart from any state; an in-flight scan is dropped silently.
        r_state     <= S_LOAD;
        r_row       <= '0;
        r_row_ready <= 1'b1;
        r_map_ready <= 1'b0;
        r_q_ready   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_row_ready <= 1'b0;
            r_q_ready   <= 1'b0;
          end
          S_LOAD: begin
            if (row_valid && r_row_ready) begin
              if (r_row == c_MAP_H8 - 8'd1) begin
                r_state     <= S_READY;
                r_row_ready <= 1'b0;
                r_map_ready <= 1'b1;
                r_q_ready   <= 1'b1;
              end else begin
                r_row <= r_row + 8'd1;
              end
            end
          end
          S_READY: begin
            if (q_valid && r_q_ready) begin
              r_state   <= S_SCAN;
              r_qx      <= {1'b0, q_x};
              r_row     <= {1'b0, q_y};
              r_cnt     <= '0;
              r_acc     <= 1'b0;
              r_q_ready <= 1'b0;
            end
          end
          S_SCAN: begin
            r_acc <= w_acc_next;
            r_row <= r_row + 8'd1;
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == c_Q_H8 - 8'd1) begin
              r_state     <= S_READY;
              r_res_valid <= 1'b1;
              r_res_hit   <= w_acc_next;
              r_q_ready   <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign row_ready = r_row_ready;
  assign map_ready = r_map_ready;
  assign q_ready   = r_q_ready;
  assign r_valid   = r_res_valid;
  assign r_hit     = r_res_hit;

  // --------------------------------------------------------------------------
  // Render pipeline stage 1: window test and tile / texel split.
  // Offsets are taken from the window origin so each tile starts at texel 0.
  // --------------------------------------------------------------------------
  logic [9:0] w_x;
  logic [9:0] w_y;
  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic       w_in_win;
  logic       w_unused_lsb;

  assign w_x          = {1'b0, h_cnt[9:1]};
  assign w_y          = {1'b0, v_cnt[9:1]};
  assign w_dx         = w_x - c_ORG_X10;
  assign w_dy         = w_y - c_ORG_Y10;
  assign w_in_win     = (w_x >= c_ORG_X10) && (w_x < c_X_END10) &&
                        (w_y >= c_ORG_Y10) && (w_y < c_Y_END10);
  assign w_unused_lsb = h_cnt[0] ^ v_cnt[0];

  logic                r_s1_in_win;
  logic [7:0]          r_s1_col;
  logic [c_ROW_AW-1:0] r_s1_row;
  logic [7:0]          r_s1_ox;
  logic [7:0]          r_s1_oy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_in_win <= 1'b0;
      r_s1_col    <= '0;
      r_s1_row    <= '0;
      r_s1_ox     <= '0;
      r_s1_oy     <= '0;
    end else begin
      r_s1_in_win <= w_in_win;
      r_s1_col    <= 8'(w_dx / c_TILE10);
      r_s1_row    <= c_ROW_AW'(w_dy / c_TILE10);
      r_s1_ox     <= 8'(w_dx % c_TILE10);
      r_s1_oy     <= 8'(w_dy % c_TILE10);
    end
  end

  // --------------------------------------------------------------------------
  // Render pipeline stage 2: map lookup and texture address.
  // Out-of-window tile indices may point past the map; in_win masks them.
  // --------------------------------------------------------------------------
  logic [MAP_W-1:0] w_rd_row;
  logic [MAP_W-1:0] w_rd_sh;
  logic             w_obj;
  logic [16:0]      r_pixel_addr;
  logic             r_is_object;

  assign w_rd_row = r_map[r_s1_row];
  assign w_rd_sh  = w_rd_row << r_s1_col;
  assign w_obj    = r_map_ready & r_s1_in_win & w_rd_sh[MAP_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_object  <= 1'b0;
      r_pixel_addr <= '0;
    end else begin
      r_is_object  <= w_obj;
      r_pixel_addr <= w_obj ? tex_addr(r_s1_ox, r_s1_oy, TEX_ROW, FB_W, FB_DEPTH)
                            : 17'd0;
    end
  end

  assign pixel_addr = r_pixel_addr;
  assign is_object  = r_is_object;

endmodule
`default_nettype wire

// File: tb/tb_tile_map_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tile_map_renderer
//  Purpose  : Self-checking bench for tile_map_renderer. Keeps the map as a
//             plain 2-D bit array and derives render and collision results
//             directly from tile geometry.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tile_map_renderer;

  localparam int MAP_W    = 40;
  localparam int MAP_H    = 40;
  localparam int TILE     = 5;
  localparam int ORG_X    = 60;
  localparam int ORG_Y    = 30;
  localparam int TEX_ROW  = 120;
  localparam int FB_W     = 320;
  localparam int FB_DEPTH = 76800;
  localparam int Q_W      = 4;
  localparam int Q_H      = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_start;
  logic             row_valid;
  logic             row_ready;
  logic [MAP_W-1:0] row_data;
  logic             map_ready;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [16:0]      pixel_addr;
  logic             is_object;
  logic             q_valid;
  logic             q_ready;
  logic [6:0]       q_x;
  logic [6:0]       q_y;
  logic             r_valid;
  logic             r_hit;

  tile_map_renderer #(
    .MAP_W (MAP_W), .MAP_H (MAP_H), .TILE (TILE), .ORG_X (ORG_X), .ORG_Y (ORG_Y),
    .TEX_ROW (TEX_ROW), .FB_W (FB_W), .FB_DEPTH (FB_DEPTH), .Q_W (Q_W), .Q_H (Q_H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_data   (row_data),
    .map_ready  (map_ready),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .pixel_addr (pixel_addr),
    .is_object  (is_object),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .q_x        (q_x),
    .q_y        (q_y),
    .r_valid    (r_valid),
    .r_hit      (r_hit)
  );

  always #5 clk = ~clk;

  // Reference state: the map as loaded, and whether loading has completed.
  logic [MAP_W-1:0] mrow [MAP_H];
  bit               m_ready;

  int n_checks = 0;
  int n_errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit wall(input int r, input int c);
    if (r < 0 || c < 0 || r >= MAP_H || c >= MAP_W) return 1'b1;
    return mrow[r][MAP_W-1-c];
  endfunction

  function automatic bit exp_hit(input int qx, input int qy);
    bit h = 1'b0;
    for (int r = qy; r < qy + Q_H; r++)
      for (int c = qx; c < qx + Q_W; c++)
        h |= wall(r, c);
    return h;
  endfunction

  function automatic void exp_pix(input int h, input int v, output bit obj, output int addr);
    int x = h / 2;
    int y = v / 2;
    obj  = 1'b0;
    addr = 0;
    if (m_ready && x >= ORG_X && x < ORG_X + MAP_W * TILE &&
        y >= ORG_Y && y < ORG_Y + MAP_H * TILE) begin
      if (wall((y - ORG_Y) / TILE, (x - ORG_X) / TILE)) begin
        obj  = 1'b1;
        addr = ((x - ORG_X) % TILE + ((y - ORG_Y) % TILE + TEX_ROW) * FB_W) % FB_DEPTH;
      end
    end
  endfunction

  // Border walls, random interior, and an open 4x4 pocket at tiles 1..4.
  task automatic make_maze(input bit empty);
    bit b;
    for (int r = 0; r < MAP_H; r++) begin
      for (int c = 0; c < MAP_W; c++) begin
        if (empty) b = 1'b0;
        else if (r == 0 || c == 0 || r == MAP_H - 1 || c == MAP_W - 1) b = 1'b1;
        else if (r >= 1 && r <= 4 && c >= 1 && c <= 4) b = 1'b0;
        else b = ($urandom_range(0, 99) < 30);
        mrow[r][MAP_W-1-c] = b;
      end
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic load_map(input bit gaps);
    int  idx    = 0;
    int  rr_cnt = 0;
    int  cyc    = 0;
    bit  hs;
    start_load();
    while (idx < MAP_H && cyc < 400) begin
      row_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      row_data  = mrow[idx];
      hs        = row_valid && row_ready;
      if (row_ready) rr_cnt++;
      if (idx == 0 || idx == MAP_H / 2) chk("map_ready_during_load", map_ready, 0);
      tick();
      cyc++;
      if (hs) idx++;
    end
    chk("load_rows_accepted", idx, MAP_H);
    chk("map_ready_after_last", map_ready, 1);
    chk("row_ready_after_last", row_ready, 0);
    if (!gaps) chk("row_ready_cycles", rr_cnt, MAP_H);
    row_valid = 1'b1;
    tick();
    row_valid = 1'b0;
    chk("row_ready_stays_low", row_ready, 0);
    m_ready = 1'b1;
  endtask

  // Random pixel stream; each output is compared two cycles after its input.
  task automatic render_stream(input int n);
    bit eo_q[$];
    int ea_q[$];
    bit eo;
    int ea;
    int h;
    int v;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        if ($urandom_range(0, 7) == 0) begin
          h = $urandom_range(0, 1023);
          v = $urandom_range(0, 1023);
        end else begin
          h = $urandom_range(100, 540);
          v = $urandom_range(40, 480);
        end
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        exp_pix(h, v, eo, ea);
        eo_q.push_back(eo);
        ea_q.push_back(ea);
      end
      tick();
      if (i >= 1) begin
        eo = eo_q.pop_front();
        ea = ea_q.pop_front();
        chk("render_is_object", is_object, eo);
        chk("render_pixel_addr", pixel_addr, ea);
      end
    end
  endtask

  // exp_const < 0 means the reference model alone decides the result.
  task automatic query(input int qx, input int qy, input int exp_const);
    int w = 0;
    while (!q_ready && w < 20) begin
      tick();
      w++;
    end
    chk("q_ready_before_query", q_ready, 1);
    q_valid = 1'b1;
    q_x     = 7'(qx);
    q_y     = 7'(qy);
    tick();
    q_valid = 1'b0;
    for (int k = 0; k < Q_H; k++) begin
      chk("scan_q_ready_low", q_ready, 0);
      chk("scan_no_r_valid", r_valid, 0);
      tick();
    end
    chk("r_valid_pulse", r_valid, 1);
    chk("r_hit_model", r_hit, exp_hit(qx, qy));
    if (exp_const >= 0) chk("r_hit_directed", r_hit, exp_const);
    tick();
    chk("r_valid_one_cycle", r_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_row_ready"}, row_ready, 0);
    chk({tag, "_map_ready"}, map_ready, 0);
    chk({tag, "_q_ready"}, q_ready, 0);
    chk({tag, "_r_valid"}, r_valid, 0);
    chk({tag, "_r_hit"}, r_hit, 0);
    chk({tag, "_pixel_addr"}, pixel_addr, 0);
    chk({tag, "_is_object"}, is_object, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    row_valid  = 1'b0;
    row_data   = '0;
    h_cnt      = '0;
    v_cnt      = '0;
    q_valid    = 1'b0;
    q_x        = '0;
    q_y        = '0;
    m_ready    = 1'b0;
    for (int r = 0; r < MAP_H; r++) mrow[r] = '0;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_row_ready", row_ready, 0);

    // Blanking before any map is loaded
    make_maze(1'b0);
    render_stream(20);

    // Continuous load of the maze
    load_map(1'b0);

    // Directed render points
    h_cnt = 10'd120; v_cnt = 10'd60;
    tick(); tick();
    chk("corner_is_object", is_object, 1);
    chk("corner_pixel_addr", pixel_addr, 38400);
    h_cnt = 10'd130; v_cnt = 10'd70;
    tick(); tick();
    chk("open_is_object", is_object, 0);
    chk("open_pixel_addr", pixel_addr, 0);
    render_stream(300);

    // Directed and random queries
    query(1, 1, 0);
    query(0, 0, 1);
    query(38, 18, 1);
    query(36, 36, -1);
    query(127, 127, 1);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 4) == 0) query($urandom_range(0, 127), $urandom_range(0, 127), -1);
      else query($urandom_range(0, 44), $urandom_range(0, 44), -1);
    end

    // Abort a scan two cycles in with load_start
    begin
      int w = 0;
      while (!q_ready && w < 20) begin tick(); w++; end
      chk("abort_q_ready", q_ready, 1);
    end
    q_valid = 1'b1; q_x = 7'd1; q_y = 7'd1;
    tick();
    q_valid = 1'b0;
    tick();
    start_load();
    chk("abort_map_ready", map_ready, 0);
    chk("abort_row_ready", row_ready, 1);
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_r_valid", r_valid, 0);
      tick();
    end
    render_stream(60);
    make_maze(1'b0);
    load_map(1'b1);
    render_stream(200);
    for (int i = 0; i < 8; i++) query($urandom_range(0, 42), $urandom_range(0, 42), -1);

    // Reset in the middle of a load, after 17 rows
    make_maze(1'b0);
    start_load();
    for (int i = 0; i < 17; i++) begin
      row_valid = 1'b1;
      row_data  = mrow[i];
      tick();
    end
    rst = 1'b1;
    row_valid = 1'b0;
    tick();
    check_all_zero("mid_load_reset");
    rst = 1'b0;
    m_ready = 1'b0;
    tick();

    // Fresh load of an empty map: no wall pixels, in-range boxes never hit
    make_maze(1'b1);
    load_map(1'b0);
    render_stream(150);
    query(0, 0, 0);
    query(36, 36, 0);
    query(37, 10, 1);
    for (int i = 0; i < 5; i++) query($urandom_range(0, 36), $urandom_range(0, 36), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
